// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: byte width and issue-FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_queue_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_END = 2'd2
    } txq_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bundle of the producer-side push/status signals and the UART-side handshake.
// Latency: n/a (wires only).
// Backpressure: producer watches full; the UART throttles the queue through uart_busy.
// Ports: wr_en/wr_data/clr_overflow (producer in), full/empty/level/idle/overflow (status out),
//        uart_transmit/uart_tx_byte (to UART), uart_busy (from UART).
// Modports: slave = queue side, master = producer/UART side.
interface uart_tx_queue_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    logic                                    wr_en;
    logic [uart_tx_queue_pkg::UART_BYTE_W-1:0] wr_data;
    logic                                    full;
    logic                                    empty;
    logic [DEPTH_LOG2:0]                     level;
    logic                                    idle;
    logic                                    overflow;
    logic                                    clr_overflow;
    logic                                    uart_transmit;
    logic [uart_tx_queue_pkg::UART_BYTE_W-1:0] uart_tx_byte;
    logic                                    uart_busy;

    modport slave (
        input  wr_en, wr_data, clr_overflow, uart_busy,
        output full, empty, level, idle, overflow, uart_transmit, uart_tx_byte
    );

    modport master (
        output wr_en, wr_data, clr_overflow, uart_busy,
        input  full, empty, level, idle, overflow, uart_transmit, uart_tx_byte
    );
endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Circular byte FIFO with a separately tracked fill level; head is presented combinationally.
// Latency: push visible in level/head one cycle after the push edge.
// Backpressure: push while full is dropped (even with a same-cycle pop); pop while empty ignored.
// Ports: clk, rst (sync, active-high), push/push_data, pop, head, full, empty, level.
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int W          = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [W-1:0]        push_data,
    input  logic                pop,
    output logic [W-1:0]        head,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (push_ok && !pop_ok) begin
                level <= level + LW'(1);
            end else if (pop_ok && !push_ok) begin
                level <= level - LW'(1);
            end
        end
    end
endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter: buffers producer bytes and issues them one at a time.
// Latency: push into empty queue with UART idle -> uart_transmit high two cycles after the push edge.
// Backpressure: full flags the producer (extra pushes dropped); uart_busy stalls issue.
// Ports: clk, rst (sync, active-high), bus (uart_tx_queue_if.slave).
// Build option: UART_TXQ_OVERFLOW_EN enables the sticky overflow flag; otherwise overflow is 0.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_queue_if.slave     bus
);
    txq_state_e             state;
    txq_state_e             state_nxt;
    logic                   transmit_q;
    logic                   transmit_nxt;
    logic [UART_BYTE_W-1:0] byte_q;
    logic [UART_BYTE_W-1:0] byte_nxt;
    logic                   pop;
    logic [UART_BYTE_W-1:0] head;
    logic                   full;
    logic                   empty;
    logic [DEPTH_LOG2:0]    level;
    logic                   overflow_q;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          (UART_BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            transmit_q <= 1'b0;
            byte_q     <= '0;
        end else begin
            state      <= state_nxt;
            transmit_q <= transmit_nxt;
            byte_q     <= byte_nxt;
        end
    end

    // The UART only samples transmit while idle, so holding the request until busy
    // rises cannot produce a second send of the same byte.
    always_comb begin
        state_nxt    = state;
        transmit_nxt = transmit_q;
        byte_nxt     = byte_q;
        pop          = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !bus.uart_busy) begin
                    pop          = 1'b1;
                    byte_nxt     = head;
                    transmit_nxt = 1'b1;
                    state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.uart_busy) begin
                    transmit_nxt = 1'b0;
                    state_nxt    = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (!bus.uart_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                transmit_nxt = 1'b0;
                state_nxt    = S_IDLE;
            end
        endcase
    end

`ifdef UART_TXQ_OVERFLOW_EN
    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (bus.wr_en && full) begin
            overflow_q <= 1'b1;
        end else if (bus.clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = bus.clr_overflow;
    assign overflow_q = 1'b0;
`endif

    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.level         = level;
    assign bus.idle          = empty && (state == S_IDLE) && !bus.uart_busy;
    assign bus.overflow      = overflow_q;
    assign bus.uart_transmit = transmit_q;
    assign bus.uart_tx_byte  = byte_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural UART transmitter (divide-by-4 bit time)
// and a serial-line decoder that checks bytes against a push-order scoreboard.
module tb_uart_tx_queue;
    localparam int DL2 = 4;
    localparam int DIV = 4;
`ifdef UART_TXQ_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH_LOG2(DL2)) bus ();

    uart_tx_queue #(.DEPTH_LOG2(DL2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    // Behavioural UART transmitter.
    logic       hold_busy = 1'b0;
    logic       stall     = 1'b0;
    logic       model_busy = 1'b0;
    logic       uart_tx   = 1'b1;
    logic [8:0] sh = '0;
    int         bits_left = 0;
    int         div_cnt   = 0;

    assign bus.uart_busy = model_busy | hold_busy;

    always @(posedge clk) begin
        if (rst) begin
            model_busy <= 1'b0;
            uart_tx    <= 1'b1;
            div_cnt    <= 0;
            bits_left  <= 0;
        end else if (!model_busy) begin
            if (bus.uart_transmit && !stall) begin
                model_busy <= 1'b1;
                uart_tx    <= 1'b0;
                sh         <= {1'b1, bus.uart_tx_byte};
                bits_left  <= 9;
                div_cnt    <= 0;
            end
        end else if (div_cnt == DIV - 1) begin
            div_cnt <= 0;
            if (bits_left == 0) begin
                model_busy <= 1'b0;
            end else begin
                uart_tx   <= sh[0];
                sh        <= sh >> 1;
                bits_left <= bits_left - 1;
            end
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial decoder: samples mid-bit and checks against the scoreboard head.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (DIV / 2) @(posedge clk);
            #1 chk("rx_start", 32'(uart_tx), 32'h0);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(posedge clk);
                #1 b[i] = uart_tx;
            end
            repeat (DIV) @(posedge clk);
            #1 chk("rx_stop", 32'(uart_tx), 32'h1);
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL rx_extra: observed byte=%0h expected none", b);
            end
            if (sb.size() > 0) begin
                chk("rx_byte", 32'(b), 32'(sb.pop_front()));
            end
        end
    end

    task automatic push(input logic [7:0] d, input bit acc);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (acc) sb.push_back(d);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!bus.idle && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.idle), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr_en        = 1'b0;
        bus.wr_data      = 8'h00;
        bus.clr_overflow = 1'b0;
        rst              = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_level",    32'(bus.level),         32'h0);
        chk("rst_empty",    32'(bus.empty),         32'h1);
        chk("rst_full",     32'(bus.full),          32'h0);
        chk("rst_transmit", 32'(bus.uart_transmit), 32'h0);
        chk("rst_txbyte",   32'(bus.uart_tx_byte),  32'h0);
        chk("rst_overflow", 32'(bus.overflow),      32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_idle",     32'(bus.idle),          32'h1);

        // 1. single byte latency and serial shape
        push(8'hA5, 1'b1);
        chk("t1_level_n1",    32'(bus.level),         32'h1);
        chk("t1_transmit_n1", 32'(bus.uart_transmit), 32'h0);
        @(negedge clk);
        chk("t1_transmit_n2", 32'(bus.uart_transmit), 32'h1);
        chk("t1_txbyte_n2",   32'(bus.uart_tx_byte),  32'hA5);
        chk("t1_level_n2",    32'(bus.level),         32'h0);
        wait_idle("t1_idle", 200);

        // 2. 16 back-to-back pushes, order preserved, never full
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 1'b1);
            chk("t2_not_full", 32'(bus.full), 32'h0);
        end
        wait_idle("t2_idle", 2000);

        // 3. fill while UART busy, 17th push dropped
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(8'h40 + 8'(i), i < 16);
            chk("t3_level", 32'(bus.level), (i < 16) ? 32'(i + 1) : 32'd16);
            chk("t3_full",  32'(bus.full),  (i >= 15) ? 32'h1 : 32'h0);
            chk("t3_ovf",   32'(bus.overflow), (i == 16) ? 32'(OVF_EN) : 32'h0);
        end
        bus.clr_overflow = 1'b1;
        @(negedge clk);
        bus.clr_overflow = 1'b0;
        chk("t3_ovf_clr", 32'(bus.overflow), 32'h0);
        bus.clr_overflow = 1'b1;
        push(8'hEE, 1'b0);
        bus.clr_overflow = 1'b0;
        chk("t3_ovf_set_wins", 32'(bus.overflow), 32'(OVF_EN));
        chk("t3_level_drop",   32'(bus.level),    32'd16);
        bus.clr_overflow = 1'b1;
        @(negedge clk);
        bus.clr_overflow = 1'b0;
        chk("t3_ovf_clr2", 32'(bus.overflow), 32'h0);
        hold_busy = 1'b0;
        wait_idle("t3_idle", 2000);

        // 4. push+pop same cycle at level 5, then more bytes across pointer wrap
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b1);
        chk("t4_level5", 32'(bus.level), 32'd5);
        hold_busy = 1'b0;
        push(8'h65, 1'b1);
        chk("t4_level_pushpop", 32'(bus.level),         32'd5);
        chk("t4_transmit",      32'(bus.uart_transmit), 32'h1);
        chk("t4_txbyte",        32'(bus.uart_tx_byte),  32'h60);
        for (int i = 0; i < 10; i++) push(8'h66 + 8'(i), 1'b1);
        wait_idle("t4_idle", 2000);

        // 5. reset while issuing with three bytes queued
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h90 + 8'(i), 1'b0);
        chk("t5_level3",   32'(bus.level),         32'd3);
        chk("t5_issuing",  32'(bus.uart_transmit), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_level",    32'(bus.level),         32'h0);
        chk("t5_rst_empty",    32'(bus.empty),         32'h1);
        chk("t5_rst_transmit", 32'(bus.uart_transmit), 32'h0);
        chk("t5_rst_idle",     32'(bus.idle),          32'h1);
        rst   = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        push(8'h3C, 1'b1);
        @(negedge clk);
        chk("t5_transmit", 32'(bus.uart_transmit), 32'h1);
        chk("t5_txbyte",   32'(bus.uart_tx_byte),  32'h3C);
        wait_idle("t5_idle", 200);

        // 6. drained: idle held, no spurious request
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t6_no_transmit", 32'(bus.uart_transmit), 32'h0);
        end
        chk("t6_idle",       32'(bus.idle), 32'h1);
        chk("t6_sb_drained", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
